seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for common-anode 7-segment displays. It replaces the fixed 8-digit alphanumeric scanner with a configurable digit count and refresh rate, plus per-digit decimal point and per-digit blink. It adds 4-bit PWM brightness, inter-digit ghost blanking and tear-free frame snapshots. It sits between game/score logic in top_level and the board pins `ca..cg`, `dp`, `an`.

---
 rtl/seg_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with PWM brightness,
// per-digit decimal point and blink, ghost blanking and frame-aligned snapshots.
module seg_scan_driver #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_BITS  = 13,
   parameter int CHAR_W     = 6,
   parameter int BLINK_BITS = 25
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_DIGITS*CHAR_W-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]        dp_in,
   input  logic [NUM_DIGITS-1:0]        blink_in,
   input  logic [3:0]                   brightness,
   output logic [6:0]                   seg_out,
   output logic                         dp_out,
   output logic [NUM_DIGITS-1:0]        strobe_out,
   output logic                         frame_pulse
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
   localparam logic [SCAN_BITS-1:0]  SLOT_ONE   = SCAN_BITS'(1);
   localparam logic [BLINK_BITS-1:0] BLINK_ONE  = BLINK_BITS'(1);
   localparam logic [CHAR_W-1:0]     CODE_BLANK = CHAR_W'(16);

   function automatic logic [6:0] decode(input logic [CHAR_W-1:0] code);
      case (code)
         6'd0:    decode = 7'b1000000;
         6'd1:    decode = 7'b1111001;
         6'd2:    decode = 7'b0100100;
         6'd3:    decode = 7'b0110000;
         6'd4:    decode = 7'b0011001;
         6'd5:    decode = 7'b0010010;
         6'd6:    decode = 7'b0000010;
         6'd7:    decode = 7'b1111000;
         6'd8:    decode = 7'b0000000;
         6'd9:    decode = 7'b0010000;
         6'd10:   decode = 7'b0001000;
         6'd11:   decode = 7'b0000011;
         6'd12:   decode = 7'b1000110;
         6'd13:   decode = 7'b0100001;
         6'd14:   decode = 7'b0000110;
         6'd15:   decode = 7'b0001110;
         6'd17:   decode = 7'b0111111;
         6'd18:   decode = 7'b0001001;
         6'd19:   decode = 7'b1100001;
         6'd20:   decode = 7'b1000111;
         6'd21:   decode = 7'b0100011;
         6'd22:   decode = 7'b0101111;
         6'd23:   decode = 7'b1000001;
         default: decode = 7'b1111111;
      endcase
   endfunction

   logic [SCAN_BITS-1:0]         r_slot_cnt;
   logic [IDX_W-1:0]             r_digit_idx;
   logic [BLINK_BITS-1:0]        r_blink_cnt;
   logic [NUM_DIGITS*CHAR_W-1:0] r_data_sh;
   logic [NUM_DIGITS-1:0]        r_dp_sh;
   logic [NUM_DIGITS-1:0]        r_blink_sh;
   logic [3:0]                   r_bright_sh;

   logic                  w_snap;
   logic [3:0]            w_phase;
   logic [CHAR_W-1:0]     w_code;
   logic                  w_blink_off;
   logic                  w_lit;
   logic [6:0]            w_seg;
   logic                  w_dp;
   logic [NUM_DIGITS-1:0] w_strobe;

   assign w_snap      = (r_digit_idx == LAST_IDX) && (r_slot_cnt == '0);
   assign w_phase     = r_slot_cnt[SCAN_BITS-1 -: 4];
   assign w_code      = r_data_sh[r_digit_idx*CHAR_W +: CHAR_W];
   assign w_blink_off = r_blink_sh[r_digit_idx] & r_blink_cnt[BLINK_BITS-1];
   // Phase 0 of every slot is a guard band so the strobe never overlaps a code change.
   assign w_lit       = (w_phase != 4'd0) && (w_phase <= r_bright_sh) && !w_blink_off;

   // Slot, blink and descending digit-index counters.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= LAST_IDX;
         r_blink_cnt <= '0;
      end else begin
         r_slot_cnt  <= r_slot_cnt + SLOT_ONE;
         r_blink_cnt <= r_blink_cnt + BLINK_ONE;
         if (&r_slot_cnt) begin
            r_digit_idx <= (r_digit_idx == '0) ? LAST_IDX : (r_digit_idx - IDX_ONE);
         end
      end
   end

   // Shadow registers loaded once per frame so mid-frame input changes never tear.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_data_sh   <= {NUM_DIGITS{CODE_BLANK}};
         r_dp_sh     <= '0;
         r_blink_sh  <= '0;
         r_bright_sh <= 4'd15;
      end else if (w_snap) begin
         r_data_sh   <= data_in;
         r_dp_sh     <= dp_in;
         r_blink_sh  <= blink_in;
         r_bright_sh <= brightness;
      end
   end

   // Next output pattern: one active-low strobe when lit, fully blank otherwise.
   always_comb begin
      w_strobe = '1;
      w_seg    = 7'h7F;
      w_dp     = 1'b1;
      if (w_lit) begin
         w_strobe[r_digit_idx] = 1'b0;
         w_seg                 = decode(w_code);
         w_dp                  = ~r_dp_sh[r_digit_idx];
      end else begin
         w_strobe = '1;
         w_seg    = 7'h7F;
         w_dp     = 1'b1;
      end
   end

   // Output registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         seg_out     <= 7'h7F;
         dp_out      <= 1'b1;
         strobe_out  <= '1;
         frame_pulse <= 1'b0;
      end else begin
         seg_out     <= w_seg;
         dp_out      <= w_dp;
         strobe_out  <= w_strobe;
         frame_pulse <= w_snap;
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized scoreboard bench for seg_scan_driver: a time-based reference model
// predicts every output cycle and a monitor compares the registered outputs.
module tb_seg_scan_driver;
   localparam int N     = 4;
   localparam int SB    = 5;
   localparam int BB    = 10;
   localparam int SLOT  = 1 << SB;
   localparam int FRAME = N * SLOT;

   logic           clk;
   logic           rst_in;
   logic [N*6-1:0] data_in;
   logic [N-1:0]   dp_in;
   logic [N-1:0]   blink_in;
   logic [3:0]     brightness;
   logic [6:0]     seg_out;
   logic           dp_out;
   logic [N-1:0]   strobe_out;
   logic           frame_pulse;

   seg_scan_driver #(.NUM_DIGITS(N), .SCAN_BITS(SB), .CHAR_W(6), .BLINK_BITS(BB)) dut (
      .clk_in     (clk),
      .rst_in     (rst_in),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blink_in   (blink_in),
      .brightness (brightness),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .strobe_out (strobe_out),
      .frame_pulse(frame_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [6:0]   seg;
      logic         dp;
      logic [N-1:0] strobe;
      logic         fp;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [6:0] seg_tab [24] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
      7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b1111111, 7'b0111111,
      7'b0001001, 7'b1100001, 7'b1000111, 7'b0100011, 7'b0101111, 7'b1000001};

   function automatic logic [6:0] ref_seg(input logic [5:0] c);
      if (c < 6'd24) return seg_tab[c];
      return 7'h7F;
   endfunction

   // Reference model: everything derives from t, the clock count since reset release.
   int unsigned    t;
   logic [N*6-1:0] m_data;
   logic [N-1:0]   m_dp;
   logic [N-1:0]   m_blink;
   logic [3:0]     m_bright;
   initial begin
      exp_t e;
      int   dig;
      int   phase;
      bit   blink_hi;
      forever begin
         @(posedge clk);
         if (rst_in) begin
            e        = '{seg: 7'h7F, dp: 1'b1, strobe: '1, fp: 1'b0};
            t        = 0;
            m_data   = {N{6'd16}};
            m_dp     = '0;
            m_blink  = '0;
            m_bright = 4'd15;
         end else begin
            dig      = (N - 1) - int'((t / SLOT) % N);
            phase    = int'((t % SLOT) / (SLOT / 16));
            blink_hi = ((t / (1 << (BB - 1))) % 2) == 1;
            if (phase != 0 && phase <= int'(m_bright) && !(m_blink[dig] && blink_hi)) begin
               e.seg    = ref_seg(m_data[dig*6 +: 6]);
               e.dp     = ~m_dp[dig];
               e.strobe = ~(N'(1) << dig);
            end else begin
               e.seg    = 7'h7F;
               e.dp     = 1'b1;
               e.strobe = '1;
            end
            e.fp = (t % FRAME) == 0;
            if ((t % FRAME) == 0) begin
               m_data   = data_in;
               m_dp     = dp_in;
               m_blink  = blink_in;
               m_bright = brightness;
            end
            t++;
         end
         q.push_back(e);
      end
   end

   // Monitor: outputs are valid every cycle, so one expectation is consumed per clock.
   initial begin
      exp_t m_e;
      forever begin
         @(posedge clk);
         #1;
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: got output with no expected entry, required one", $time);
         end else begin
            m_e = q.pop_front();
            if (seg_out !== m_e.seg || dp_out !== m_e.dp || strobe_out !== m_e.strobe ||
                frame_pulse !== m_e.fp) begin
               n_fail++;
               $display("FAIL outputs at %0t: got seg=%b dp=%b strobe=%b fp=%b, required seg=%b dp=%b strobe=%b fp=%b",
                        $time, seg_out, dp_out, strobe_out, frame_pulse,
                        m_e.seg, m_e.dp, m_e.strobe, m_e.fp);
            end
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < N; i++) data_in[i*6 +: 6] = 6'($urandom_range(0, 63));
      dp_in      = N'($urandom);
      blink_in   = N'($urandom);
      brightness = 4'($urandom_range(0, 15));
   endtask

   initial begin
      rst_in     = 1'b1;
      data_in    = {6'd3, 6'd2, 6'd1, 6'd0};
      dp_in      = '0;
      blink_in   = '0;
      brightness = 4'd15;
      run(3);
      rst_in = 1'b0;
      run(2 * FRAME + 40);
      brightness = 4'd0;
      run(2 * FRAME + 2);
      brightness = 4'd8;
      run(2 * FRAME + 2);
      brightness = 4'd15;
      run(50);
      data_in = {6'd17, 6'd40, 6'd23, 6'd10};
      run(2 * FRAME + 30);
      blink_in = 4'b0001;
      dp_in    = 4'b0100;
      run(2100);
      for (int k = 0; k < 12; k++) begin
         run($urandom_range(20, 200));
         rand_inputs();
      end
      run(77);
      rst_in = 1'b1;
      run(1);
      rst_in = 1'b0;
      run(2 * FRAME + 10);
      rst_in = 1'b1;
      run(1 + $urandom_range(0, 3));
      rst_in = 1'b0;
      rand_inputs();
      run(3 * FRAME);
      run(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
